// File: rtl/signed_product_accumulator.sv
// Accumulates a valid/ready stream of 8-bit signed products into per-frame sums.
// Each in_last closes a frame and registers its sum, sample count and sticky overflow flag.
module signed_product_accumulator #(
  parameter int ACC_WIDTH = 12,
  parameter int CNT_WIDTH = 8,
  parameter bit SATURATE  = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [7:0]           in_product,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_sum,
  output logic [CNT_WIDTH-1:0] out_count,
  output logic                 out_overflow
);

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  state_t               r_state;
  logic [ACC_WIDTH-1:0] r_acc;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_ovf;
  logic [ACC_WIDTH-1:0] r_out_sum;
  logic [CNT_WIDTH-1:0] r_out_count;
  logic                 r_out_overflow;

  logic                 w_accept;
  logic                 w_out_hs;
  logic [ACC_WIDTH:0]   w_ext;
  logic [ACC_WIDTH:0]   w_sum;
  logic                 w_ovf;
  logic [ACC_WIDTH-1:0] w_next_acc;
  logic [CNT_WIDTH-1:0] w_cnt_inc;

  assign out_valid    = (r_state == HOLD);
  assign out_sum      = r_out_sum;
  assign out_count    = r_out_count;
  assign out_overflow = r_out_overflow;

  // One result slot: a held result blocks input until it is consumed.
  assign in_ready = !out_valid || out_ready;
  assign w_accept = in_valid && in_ready;
  assign w_out_hs = out_valid && out_ready;

  always_comb begin
    w_ext      = {{(ACC_WIDTH-7){in_product[7]}}, in_product};
    w_sum      = {r_acc[ACC_WIDTH-1], r_acc} + w_ext;
    w_ovf      = w_sum[ACC_WIDTH] ^ w_sum[ACC_WIDTH-1];
    w_next_acc = w_sum[ACC_WIDTH-1:0];
    if (SATURATE && w_ovf) begin
      w_next_acc = w_sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
    end
    w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= ACCUM;
      r_acc          <= '0;
      r_cnt          <= '0;
      r_ovf          <= 1'b0;
      r_out_sum      <= '0;
      r_out_count    <= '0;
      r_out_overflow <= 1'b0;
    end else begin
      if (w_accept && in_last) begin
        r_out_sum      <= w_next_acc;
        r_out_count    <= w_cnt_inc;
        r_out_overflow <= r_ovf | w_ovf;
        r_acc          <= '0;
        r_cnt          <= '0;
        r_ovf          <= 1'b0;
        r_state        <= HOLD;
      end else begin
        if (w_accept) begin
          r_acc <= w_next_acc;
          r_cnt <= w_cnt_inc;
          r_ovf <= r_ovf | w_ovf;
        end
        if (w_out_hs) begin
          r_state <= ACCUM;
        end
      end
    end
  end

endmodule
